memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Data-memory stage between execute and writeback.
- Takes the ALU-computed address and store data, runs a request/grant/response handshake with a variable-latency data memory, and stalls the pipeline until the access completes.
- Formats load data (byte/half extract, sign/zero extend) onto memory_data_o, which feeds the writeback stage's memory-data input.
- Detects misaligned accesses and blocks them from reaching memory.

Parameters:
- DWIDTH, 32: data width; the block is defined for 32 only.
- AWIDTH, 32: address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  instruction present from execute
- memren_i  in  1  load instruction
- memwren_i  in  1  store instruction
- funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr_i  in  AWIDTH  byte address (ALU result)
- store_data_i  in  DWIDTH  rs2 value
- stall_o  out  1  hold upstream stages
- done_o  out  1  one-cycle pulse when an access retires
- misaligned_o  out  1  one-cycle pulse on a rejected misaligned access
- memory_data_o  out  DWIDTH  formatted load data
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  AWIDTH  word-aligned address; addr[1:0] forced to 0
- dmem_wdata_o  out  DWIDTH  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DWIDTH  read data word

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All outputs are 0, including memory_data_o and all dmem_* outputs.
  - A request in flight is abandoned; dmem_req_o drops immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accept when valid_i & (memren_i | memwren_i). memren_i takes priority if both are set.
  - On accept, latch addr, store data, funct3 and we, and assert stall_o combinationally in the same cycle.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no request is issued. Go to DONE with misaligned_o pulsed in the DONE cycle; memory_data_o is unchanged.
  - Otherwise go to REQ.
  - valid_i with no memory op: ignored, stall_o=0.
- REQ:
  - dmem_req_o=1; address, wdata, be and we are held stable from registers until grant.
  - Store with gnt: go to DONE (a store retires on grant).
  - Load with gnt & !rvalid: go to WAIT.
  - Load with gnt & rvalid in the same cycle: capture data and go to DONE.
  - rvalid without gnt: ignored.
- WAIT:
  - dmem_req_o=0.
  - On rvalid: register the formatted data into memory_data_o and go to DONE.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle, then go to IDLE.
  - valid_i is ignored in DONE; upstream advances on this edge.
- stall_o = REQ | WAIT | (IDLE & accept).
- Minimum latency:
  - Load: 1 (REQ) + 0 (WAIT) + 1 (DONE) cycles after accept.
  - Store: REQ + DONE.
- Store formatting, off = addr[1:0]:
  - B: be = 4'b0001<<off; wdata = byte replicated x4.
  - H: be = 4'b0011<<off; wdata = half replicated x2.
  - W: be = 4'b1111.
  - Undefined funct3 is treated as W.
- Load formatting: select the lane by off.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
  - Undefined funct3 is treated as W.
  - dmem_be_o for loads follows the same rule as stores.
- memory_data_o holds its value until the next load completes; stores and misaligned accesses do not alter it.
- A late dmem_rvalid_i in IDLE or DONE (e.g. after reset) is ignored.

Test Plan:
- LW at 0x100, rdata 0xDEADBEEF, gnt cycle 1, rvalid 2 cycles later -> dmem_addr_o=0x100, be=1111, stall_o high through WAIT, memory_data_o=0xDEADBEEF, done_o single pulse.
- LB at 0x103, rdata 0x80FF_0000 -> be=1000, memory_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, store_data 0x1234ABCD, gnt immediate -> dmem_addr_o=0x200, be=1100, wdata=0xABCDABCD, we=1, done_o 2 cycles after accept.
- LW at 0x101 -> dmem_req_o never asserts, misaligned_o and done_o pulse together, memory_data_o unchanged.
- Load with gnt and rvalid in the same REQ cycle, rdata 0x0000_7FFE, LH at 0x0 -> memory_data_o=0x00007FFE, no WAIT state.
- rst_ni low while in WAIT, then a stray rvalid after reset release -> all outputs 0, state IDLE, stray rvalid ignored, memory_data_o stays 0.

Source files
------------

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Data-memory stage sitting between execute and writeback. It takes the
// ALU-computed byte address and the store data, runs a request/grant/response
// handshake with a variable-latency data memory, and stalls the pipeline until
// the access retires. Load data is lane-selected and sign/zero extended onto
// memory_data_o. Misaligned half/word accesses never reach memory; they retire
// through DONE with a misaligned_o pulse instead.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i              instruction present from execute
//   memren_i, memwren_i  load / store instruction (load wins if both set)
//   funct3_i             access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i               byte address
//   store_data_i         rs2 value
//   stall_o              hold upstream stages
//   done_o               one-cycle pulse when an access retires
//   misaligned_o         one-cycle pulse on a rejected misaligned access
//   memory_data_o        formatted load data, held until the next load retires
//   dmem_req_o/we_o/addr_o/wdata_o/be_o   request side of the memory port
//   dmem_gnt_i/rvalid_i/rdata_i           response side of the memory port
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module memory_access #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                mis_q, mis_d;
    logic [DWIDTH-1:0]   mem_data_q, mem_data_d;

    logic                accept;
    logic [3:0]          be_new;
    logic [DWIDTH-1:0]   wdata_new;
    logic                mis_new;
    logic [DWIDTH-1:0]   lane;
    logic [DWIDTH-1:0]   load_fmt;
    logic                capture;

    // Gating with rst_ni keeps stall_o low while reset is asserted even if
    // execute presents a valid memory op.
    assign accept = rst_ni & valid_i & (memren_i | memwren_i);

    // Byte enables, lane-replicated store data and alignment check for the
    // incoming access. Only funct3[1:0] encodes size, so BU/HU share the B/H
    // enables and every undefined size code falls into the word case.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = store_data_i;
        mis_new   = |addr_i[1:0];
        case (funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
                mis_new   = 1'b0;
            end
            2'b01: begin
                be_new    = 4'b0011 << addr_i[1:0];
                wdata_new = {2{store_data_i[15:0]}};
                mis_new   = addr_i[0];
            end
            default: ;
        endcase
    end

    // Load formatting: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane[7]}},  lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'd0, lane[7:0]};
            3'b101:  load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    // Read data is taken either in the grant cycle (gnt and rvalid together)
    // or later in WAIT. rvalid without gnt in REQ, or in IDLE/DONE, is stray.
    assign capture = ((state_q == REQ) & dmem_gnt_i & dmem_rvalid_i & ~we_q) |
                     ((state_q == WAIT) & dmem_rvalid_i);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        mis_d      = mis_q;
        mem_data_d = capture ? load_fmt : mem_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_new;
                    be_d     = be_new;
                    we_d     = ~memren_i;
                    funct3_d = funct3_i;
                    mis_d    = mis_new;
                    state_d  = mis_new ? DONE : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q || dmem_rvalid_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            mis_q      <= 1'b0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            mis_q      <= mis_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign stall_o       = (state_q == REQ) | (state_q == WAIT) |
                           ((state_q == IDLE) & accept);
    assign done_o        = (state_q == DONE);
    assign misaligned_o  = (state_q == DONE) & mis_q;
    assign memory_data_o = mem_data_q;
    assign dmem_req_o    = (state_q == REQ);
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = {addr_q[AWIDTH-1:2], 2'b00};
    assign dmem_wdata_o  = wdata_q;
    assign dmem_be_o     = be_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Self-checking bench for memory_access. Inputs are driven just after each
// falling edge and outputs are sampled 1ns later, so every sample sees the
// settled state of the current cycle. Expected byte enables, store data, load
// results and misalignment come from arithmetic on the access size and byte
// offset, not from the stage's own decode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_memory_access;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic        done_o;
    logic        misaligned_o;
    logic [31:0] memory_data_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int          tests;
    int          fails;
    logic [31:0] model_mem;

    memory_access #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .memren_i      (memren_i),
        .memwren_i     (memwren_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .store_data_i  (store_data_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .misaligned_o  (misaligned_o),
        .memory_data_o (memory_data_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Bytes touched by an access of this funct3.
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Value a load returns, from the word, byte offset and signedness.
    function automatic logic [31:0] load_value(input logic [2:0] f3,
                                               input int off,
                                               input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * off);
        case (f3)
            3'b000: begin v = v & 32'hFF;   if (v > 32'd127)   v = v - 32'd256;   end
            3'b001: begin v = v & 32'hFFFF; if (v > 32'd32767) v = v - 32'd65536; end
            3'b100: v = v & 32'hFF;
            3'b101: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    // One complete access: accept, REQ (gnt after gnt_delay cycles), optional
    // WAIT (rvalid after rv_delay cycles), DONE, and the idle cycle after.
    task automatic run_access(input bit is_load, input bit both_ops,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int gnt_delay, input int rv_delay,
                              input bit same_cycle, input bit stray_rv);
        int          n;
        int          off;
        bit          mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        n        = access_bytes(f3);
        off      = int'(a[1:0]);
        mis      = (off % n) != 0;
        exp_be   = 4'(((1 << n) - 1) << off);
        exp_addr = a - 32'(off);
        if (n == 1)      exp_wd = 32'(sd[7:0]) * 32'h01010101;
        else if (n == 2) exp_wd = 32'(sd[15:0]) * 32'h00010001;
        else             exp_wd = sd;

        @(negedge clk_i);
        valid_i = 1'b1; memren_i = is_load; memwren_i = is_load ? both_ops : 1'b1;
        funct3_i = f3; addr_i = a; store_data_i = sd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
        #1;
        tests++; if (stall_o !== 1'b1) begin fails++; $display("[TB] FAIL accept_stall: got %b expected 1", stall_o); end
        tests++; if (dmem_req_o !== 1'b0) begin fails++; $display("[TB] FAIL accept_req: got %b expected 0", dmem_req_o); end

        if (!mis) begin
            for (int i = 0; i <= gnt_delay; i++) begin
                @(negedge clk_i);
                valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
                dmem_gnt_i    = (i == gnt_delay);
                dmem_rvalid_i = (i == gnt_delay) ? (is_load && same_cycle) : stray_rv;
                dmem_rdata_i  = ((i == gnt_delay) && same_cycle) ? rd : $urandom;
                #1;
                tests++; if (dmem_req_o !== 1'b1) begin fails++; $display("[TB] FAIL req_high: got %b expected 1", dmem_req_o); end
                tests++; if (stall_o !== 1'b1) begin fails++; $display("[TB] FAIL req_stall: got %b expected 1", stall_o); end
                tests++; if (dmem_addr_o !== exp_addr) begin fails++; $display("[TB] FAIL req_addr: got %h expected %h", dmem_addr_o, exp_addr); end
                tests++; if (dmem_be_o !== exp_be) begin fails++; $display("[TB] FAIL req_be: got %b expected %b", dmem_be_o, exp_be); end
                tests++; if (dmem_we_o !== !is_load) begin fails++; $display("[TB] FAIL req_we: got %b expected %b", dmem_we_o, !is_load); end
                if (!is_load) begin
                    tests++; if (dmem_wdata_o !== exp_wd) begin fails++; $display("[TB] FAIL req_wdata: got %h expected %h", dmem_wdata_o, exp_wd); end
                end
            end
            if (is_load && !same_cycle) begin
                for (int i = 0; i <= rv_delay; i++) begin
                    @(negedge clk_i);
                    dmem_gnt_i    = 1'b0;
                    dmem_rvalid_i = (i == rv_delay);
                    dmem_rdata_i  = (i == rv_delay) ? rd : $urandom;
                    #1;
                    tests++; if (dmem_req_o !== 1'b0) begin fails++; $display("[TB] FAIL wait_req: got %b expected 0", dmem_req_o); end
                    tests++; if (stall_o !== 1'b1) begin fails++; $display("[TB] FAIL wait_stall: got %b expected 1", stall_o); end
                end
            end
            if (is_load) model_mem = load_value(f3, off, rd);
        end

        @(negedge clk_i);
        valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = stray_rv; dmem_rdata_i = $urandom;
        #1;
        tests++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL done_pulse: got %b expected 1", done_o); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("[TB] FAIL done_stall: got %b expected 0", stall_o); end
        tests++; if (misaligned_o !== mis) begin fails++; $display("[TB] FAIL done_misaligned: got %b expected %b", misaligned_o, mis); end
        tests++; if (dmem_req_o !== 1'b0) begin fails++; $display("[TB] FAIL done_req: got %b expected 0", dmem_req_o); end
        tests++; if (memory_data_o !== model_mem) begin fails++; $display("[TB] FAIL done_data: got %h expected %h", memory_data_o, model_mem); end

        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        #1;
        tests++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL done_single: got %b expected 0", done_o); end
        tests++; if (misaligned_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_single: got %b expected 0", misaligned_o); end
        tests++; if (memory_data_o !== model_mem) begin fails++; $display("[TB] FAIL data_hold: got %h expected %h", memory_data_o, model_mem); end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = 3'b000; addr_i = '0; store_data_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        model_mem = '0;
        repeat (2) @(negedge clk_i);
        #1;
        tests++; if ({stall_o, done_o, misaligned_o, dmem_req_o, dmem_we_o} !== 5'b0) begin fails++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {stall_o, done_o, misaligned_o, dmem_req_o, dmem_we_o}); end
        tests++; if (memory_data_o !== 32'd0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", memory_data_o); end
        tests++; if ({dmem_addr_o, dmem_wdata_o, dmem_be_o} !== 68'd0) begin fails++; $display("[TB] FAIL reset_bus: got %h %h %b expected zeros", dmem_addr_o, dmem_wdata_o, dmem_be_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_lw;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_lb_lbu;
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0, 1'b0);
        tests++; if (model_mem !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL lb_model: got %h expected FFFFFF80", model_mem); end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sh;
        run_access(1'b0, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        run_access(1'b0, 1'b0, 3'b001, 32'h203, 32'h5555AAAA, 32'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle;
        run_access(1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h00007FFE, 2, 0, 1'b1, 1'b1);
    endtask

    task automatic test_valid_no_op;
        @(negedge clk_i);
        valid_i = 1'b1; memren_i = 1'b0; memwren_i = 1'b0; addr_i = 32'h300;
        #1;
        tests++; if (stall_o !== 1'b0) begin fails++; $display("[TB] FAIL noop_stall: got %b expected 0", stall_o); end
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        tests++; if ({dmem_req_o, done_o} !== 2'b00) begin fails++; $display("[TB] FAIL noop_idle: got %b expected 00", {dmem_req_o, done_o}); end
    endtask

    task automatic test_random;
        logic [2:0]  load_codes [5];
        logic [2:0]  f3;
        logic [31:0] a;
        bit          is_load;
        load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int k = 0; k < 150; k++) begin
            is_load = $urandom_range(0, 1);
            f3 = is_load ? load_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_access(is_load, 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk_i);
        valid_i = 1'b1; memren_i = 1'b1; memwren_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h40;
        @(negedge clk_i);
        valid_i = 1'b0; memren_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        tests++; if ({dmem_req_o, stall_o} !== 2'b01) begin fails++; $display("[TB] FAIL pre_reset_wait: got %b expected 01", {dmem_req_o, stall_o}); end
        rst_ni = 1'b0;
        #1;
        model_mem = '0;
        tests++; if ({stall_o, done_o, misaligned_o, dmem_req_o, dmem_we_o} !== 5'b0) begin fails++; $display("[TB] FAIL wait_reset_ctrl: got %b expected 00000", {stall_o, done_o, misaligned_o, dmem_req_o, dmem_we_o}); end
        tests++; if ({dmem_addr_o, dmem_wdata_o, dmem_be_o, memory_data_o} !== 100'd0) begin fails++; $display("[TB] FAIL wait_reset_bus: got %h %h %b %h expected zeros", dmem_addr_o, dmem_wdata_o, dmem_be_o, memory_data_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5A5A5A5A;
        #1;
        tests++; if ({stall_o, done_o, dmem_req_o} !== 3'b000) begin fails++; $display("[TB] FAIL stray_ctrl: got %b expected 000", {stall_o, done_o, dmem_req_o}); end
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        #1;
        tests++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL stray_done: got %b expected 0", done_o); end
        tests++; if (memory_data_o !== 32'd0) begin fails++; $display("[TB] FAIL stray_data: got %h expected 0", memory_data_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_same_cycle();
        test_valid_no_op();
        test_random();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
